fifo_ptr_writeback_scheduler: RTL and testbench
===============================================

# fifo_ptr_writeback_scheduler

Sequences write-back of the FIFO controller's `producer_tail_ptr_o` and `consumer_head_ptr_o` to their memory-resident pointer slots, so remote producers and consumers can observe progress. It sits beside the FIFO controller and owns one write-request port toward the memory interface. Both pointers share that port under round-robin arbitration, with one write outstanding at a time and a programmable back-off between writes.

## Interface
Parameters:
- `PtrWidth`, 64: width of each pointer value.
- `AddrWidth`, 64: width of the pointer-slot addresses.
- `WaitWidth`, 14: width of the back-off count.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  allows new write-backs to issue.
- `wait_cycles_i`  in  WaitWidth  number of idle cycles after each ack before the next issue.
- `prod_ptr_addr_i`  in  AddrWidth  address of the producer tail slot.
- `cons_ptr_addr_i`  in  AddrWidth  address of the consumer head slot.
- `producer_tail_ptr_i`  in  PtrWidth  live producer tail pointer.
- `consumer_head_ptr_i`  in  PtrWidth  live consumer head pointer.
- `wr_valid_o`  out  1  write request valid.
- `wr_ready_i`  in  1  write request accepted.
- `wr_addr_o`  out  AddrWidth  write address.
- `wr_data_o`  out  PtrWidth  write data.
- `wr_ack_i`  in  1  write completed (one-cycle pulse).
- `busy_o`  out  1  high whenever state is not IDLE.
- `prod_written_o`  out  PtrWidth  last acknowledged producer value.
- `cons_written_o`  out  PtrWidth  last acknowledged consumer value.

## Operation
- Shadow registers `prod_written_o` and `cons_written_o` reset to 0, so pointers that start at 0 are clean.
- Dirty conditions (combinational):
  - `dirty_p = producer_tail_ptr_i != prod_written_o`
  - `dirty_c = consumer_head_ptr_i != cons_written_o`
- Round-robin state `last_sel` resets to CONS, so the producer wins the first tie. When both pointers are dirty, the grant goes to the one not served last.
- FSM states: IDLE, ISSUE, WAIT_ACK, BACKOFF.
  - IDLE: if `enable_i` is high and (`dirty_p` or `dirty_c`), latch `sel`, the address and the live pointer value into registers, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: `wr_valid_o=1`, and `wr_addr_o`/`wr_data_o` come from the latched registers, held stable. On `wr_valid_o & wr_ready_i`, go to WAIT_ACK.
  - WAIT_ACK: on `wr_ack_i`, copy the latched data into the shadow selected by `sel` and set `last_sel=sel`. Then go to IDLE if `wait_cycles_i==0`; otherwise load the counter with `wait_cycles_i` and go to BACKOFF.
  - BACKOFF: decrement the counter each cycle. When the counter is 1, go to IDLE. Total time in BACKOFF is exactly `wait_cycles_i` cycles.
- Coalescing: a pointer that changes while its write is in flight stays dirty, because the shadow takes the latched value, not the live one. That pointer is then rewritten with its newest value. Intermediate values are never queued.
- Enable: `enable_i` is sampled only in IDLE. If `enable_i` drops during ISSUE, WAIT_ACK or BACKOFF, the current write completes and is never retracted; the FSM then holds in IDLE.
- `wr_ack_i` is ignored outside WAIT_ACK. An ack in the same cycle as the request handshake is illegal; the bench asserts against it.
- `wait_cycles_i` is sampled only on the WAIT_ACK to BACKOFF transition.

## Timing
- Reset values: `wr_valid_o=0`, `wr_addr_o=0`, `wr_data_o=0`, `busy_o=0`, `prod_written_o=0`, `cons_written_o=0`, state IDLE, `last_sel`=CONS.
- All outputs are registered, except `busy_o`, which is decoded directly from the state register.
- Issue latency: dirty and enabled in IDLE at cycle t gives `wr_valid_o=1` at cycle t+1.
- Valid/ready rule: once asserted, `wr_valid_o`, `wr_addr_o` and `wr_data_o` are held until the handshake cycle. `wr_valid_o` falls in the cycle after the handshake.
- After an ack at cycle a, the shadow update is visible at a+1.
  - If `wait_cycles_i=0`: state is IDLE at a+1 and the next `wr_valid_o` is at a+2 at the earliest.
  - If `wait_cycles_i=W`: state is BACKOFF for cycles a+1..a+W, IDLE at a+W+1, and the next `wr_valid_o` is at a+W+2.
- Reset asserted mid-operation clears all state immediately and asynchronously; `wr_valid_o` drops without waiting for `clk`. An ack arriving after reset is ignored.

## Test plan
- Reset: hold `rst_n=0` with nonzero pointers → all outputs are 0 and `busy_o=0`. Release reset → the first write is to the producer slot, since the producer wins the first tie.
- Single update: set `producer_tail_ptr_i` to 0x10 at cycle t with `wr_ready_i=1` and `prod_ptr_addr_i=0x1000` → `wr_valid_o=1` at t+1 with addr 0x1000 and data 0x10. Pulse the ack 2 cycles later → `prod_written_o=0x10` on the next cycle and `busy_o` returns to 0.
- Round-robin plus back-off: with `wait_cycles_i=3`, make both pointers dirty (0x4 and 0x8) → the producer write goes first, then the consumer write. The second `wr_valid_o` rises exactly 5 cycles after the first ack.
- Backpressure and coalescing: hold `wr_ready_i=0` for 5 cycles while the producer pointer goes 0x10 to 0x20 → `wr_data_o` stays 0x10 until the handshake. After the ack, a second write carries 0x20, and no write of any other value is issued.
- Enable: with `enable_i=0` and a dirty pointer → no request for 20 cycles. Drop `enable_i` during ISSUE → that write completes and no further write issues until `enable_i` is high again.
- Reset mid-op: assert `rst_n` low in WAIT_ACK → `wr_valid_o` and both shadows are 0 immediately. After release, the still-dirty pointer is reissued with its current value.

Source files
------------

// File: rtl/fifo_ptr_writeback_scheduler_if.sv
// Write-request channel between the pointer write-back scheduler and the memory interface.
// The scheduler drives request/address/data; the memory side returns ready and a completion ack.
interface fifo_ptr_writeback_scheduler_if #(
   parameter int PtrWidth  = 64,
   parameter int AddrWidth = 64
);
   logic                 wr_valid_o;
   logic                 wr_ready_i;
   logic [AddrWidth-1:0] wr_addr_o;
   logic [PtrWidth-1:0]  wr_data_o;
   logic                 wr_ack_i;

   modport master (
      output wr_valid_o,
      output wr_addr_o,
      output wr_data_o,
      input  wr_ready_i,
      input  wr_ack_i
   );

   modport slave (
      input  wr_valid_o,
      input  wr_addr_o,
      input  wr_data_o,
      output wr_ready_i,
      output wr_ack_i
   );
endinterface

// File: rtl/fifo_ptr_writeback_scheduler.sv
// Writes the FIFO producer tail / consumer head pointers back to their memory slots,
// round-robin between the two, one write outstanding, with a programmable back-off after each ack.
module fifo_ptr_writeback_scheduler #(
   parameter int PtrWidth  = 64,
   parameter int AddrWidth = 64,
   parameter int WaitWidth = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable_i,
   input  logic [WaitWidth-1:0] wait_cycles_i,
   input  logic [AddrWidth-1:0] prod_ptr_addr_i,
   input  logic [AddrWidth-1:0] cons_ptr_addr_i,
   input  logic [PtrWidth-1:0]  producer_tail_ptr_i,
   input  logic [PtrWidth-1:0]  consumer_head_ptr_i,
   fifo_ptr_writeback_scheduler_if.master wr,
   output logic                 busy_o,
   output logic [PtrWidth-1:0]  prod_written_o,
   output logic [PtrWidth-1:0]  cons_written_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_ACK = 2'd2,
      BACKOFF  = 2'd3
   } state_t;

   localparam logic                 SelProd = 1'b0;
   localparam logic                 SelCons = 1'b1;
   localparam logic [WaitWidth-1:0] CntZero = {WaitWidth{1'b0}};
   localparam logic [WaitWidth-1:0] CntOne  = {{(WaitWidth-1){1'b0}}, 1'b1};

   state_t                 state_r,    state_s;
   logic                   sel_r,      sel_s;
   logic                   last_sel_r, last_sel_s;
   logic                   valid_r,    valid_s;
   logic [AddrWidth-1:0]   addr_r,     addr_s;
   logic [PtrWidth-1:0]    data_r,     data_s;
   logic [WaitWidth-1:0]   cnt_r,      cnt_s;
   logic [PtrWidth-1:0]    prod_sh_r,  prod_sh_s;
   logic [PtrWidth-1:0]    cons_sh_r,  cons_sh_s;

   logic                   dirty_p_s;
   logic                   dirty_c_s;
   logic                   grant_s;

   // Next-state, request latching, shadow update and back-off counting.
   always_comb begin
      state_s    = state_r;
      sel_s      = sel_r;
      last_sel_s = last_sel_r;
      valid_s    = valid_r;
      addr_s     = addr_r;
      data_s     = data_r;
      cnt_s      = cnt_r;
      prod_sh_s  = prod_sh_r;
      cons_sh_s  = cons_sh_r;

      dirty_p_s = (producer_tail_ptr_i != prod_sh_r);
      dirty_c_s = (consumer_head_ptr_i != cons_sh_r);

      // On a tie the pointer not served last wins; otherwise whichever is dirty.
      if (dirty_p_s && dirty_c_s) begin
         grant_s = (last_sel_r == SelCons) ? SelProd : SelCons;
      end else if (dirty_p_s) begin
         grant_s = SelProd;
      end else begin
         grant_s = SelCons;
      end

      case (state_r)
         IDLE: begin
            if (enable_i && (dirty_p_s || dirty_c_s)) begin
               state_s = ISSUE;
               sel_s   = grant_s;
               valid_s = 1'b1;
               if (grant_s == SelCons) begin
                  addr_s = cons_ptr_addr_i;
                  data_s = consumer_head_ptr_i;
               end else begin
                  addr_s = prod_ptr_addr_i;
                  data_s = producer_tail_ptr_i;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            if (valid_r && wr.wr_ready_i) begin
               state_s = WAIT_ACK;
               valid_s = 1'b0;
            end else begin
               state_s = ISSUE;
            end
         end
         WAIT_ACK: begin
            if (wr.wr_ack_i) begin
               // The shadow takes the latched value so a pointer that moved in flight stays dirty.
               if (sel_r == SelCons) begin
                  cons_sh_s = data_r;
               end else begin
                  prod_sh_s = data_r;
               end
               last_sel_s = sel_r;
               if (wait_cycles_i == CntZero) begin
                  state_s = IDLE;
               end else begin
                  cnt_s   = wait_cycles_i;
                  state_s = BACKOFF;
               end
            end else begin
               state_s = WAIT_ACK;
            end
         end
         BACKOFF: begin
            if (cnt_r <= CntOne) begin
               cnt_s   = CntZero;
               state_s = IDLE;
            end else begin
               cnt_s   = cnt_r - CntOne;
               state_s = BACKOFF;
            end
         end
         default: begin
            state_s = IDLE;
            valid_s = 1'b0;
            cnt_s   = CntZero;
         end
      endcase
   end

   // State and datapath registers; reset clears everything at once, including the live request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         sel_r      <= SelProd;
         last_sel_r <= SelCons;
         valid_r    <= 1'b0;
         addr_r     <= {AddrWidth{1'b0}};
         data_r     <= {PtrWidth{1'b0}};
         cnt_r      <= CntZero;
         prod_sh_r  <= {PtrWidth{1'b0}};
         cons_sh_r  <= {PtrWidth{1'b0}};
      end else begin
         state_r    <= state_s;
         sel_r      <= sel_s;
         last_sel_r <= last_sel_s;
         valid_r    <= valid_s;
         addr_r     <= addr_s;
         data_r     <= data_s;
         cnt_r      <= cnt_s;
         prod_sh_r  <= prod_sh_s;
         cons_sh_r  <= cons_sh_s;
      end
   end

   assign wr.wr_valid_o   = valid_r;
   assign wr.wr_addr_o    = addr_r;
   assign wr.wr_data_o    = data_r;
   assign busy_o          = (state_r != IDLE);
   assign prod_written_o  = prod_sh_r;
   assign cons_written_o  = cons_sh_r;

endmodule

// File: tb/tb_fifo_ptr_writeback_scheduler.sv
// Random-stimulus bench: a transaction-timing reference model pushes expected requests into a queue
// that an independent monitor pops whenever the scheduler raises a write request.
module tb_fifo_ptr_writeback_scheduler;
   localparam int PW = 64;
   localparam int AW = 64;
   localparam int WW = 14;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [PW-1:0] data;
   } req_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable;
   logic [WW-1:0] wait_cycles;
   logic [AW-1:0] prod_addr, cons_addr;
   logic [PW-1:0] prod_ptr, cons_ptr;
   logic          busy;
   logic [PW-1:0] prod_wr, cons_wr;

   always #5 clk = ~clk;

   fifo_ptr_writeback_scheduler_if #(.PtrWidth(PW), .AddrWidth(AW)) wr_bus ();

   fifo_ptr_writeback_scheduler #(.PtrWidth(PW), .AddrWidth(AW), .WaitWidth(WW)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .enable_i            (enable),
      .wait_cycles_i       (wait_cycles),
      .prod_ptr_addr_i     (prod_addr),
      .cons_ptr_addr_i     (cons_addr),
      .producer_tail_ptr_i (prod_ptr),
      .consumer_head_ptr_i (cons_ptr),
      .wr                  (wr_bus.master),
      .busy_o              (busy),
      .prod_written_o      (prod_wr),
      .cons_written_o      (cons_wr)
   );

   int     n_vec = 0;
   int     n_err = 0;
   int     n_rst = 0;
   bit     mon_on = 1'b0;
   req_t   exp_q[$];

   // Reference model: what the scheduler should look like after each clock edge.
   logic [PW-1:0] m_prod_sh, m_cons_sh, m_data;
   bit            m_last_cons, m_sel_cons, m_pending, m_vld, m_hsdone, m_busy;
   longint        k, free_at, ack_at;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] rnd_ptr();
      if ($urandom_range(0, 1) == 0) return PW'($urandom_range(0, 7));
      return {$urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_prod_sh   = '0;
      m_cons_sh   = '0;
      m_data      = '0;
      m_last_cons = 1'b1;
      m_sel_cons  = 1'b0;
      m_pending   = 1'b0;
      m_vld       = 1'b0;
      m_hsdone    = 1'b0;
      m_busy      = 1'b0;
      free_at     = 0;
      ack_at      = -1;
      exp_q.delete();
   endtask

   // One clock: choose inputs at the negedge, then predict the effect of the coming posedge.
   task automatic step(input bit rnd);
      bit rdy, hs, real_ack, ack, dp, dc;
      @(negedge clk);
      rdy      = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      hs       = m_vld && rdy;
      real_ack = (ack_at == k);
      ack      = real_ack || (rnd && !m_hsdone && !hs && ($urandom_range(0, 9) == 0));
      if (rnd) begin
         if (enable) enable = ($urandom_range(0, 31) != 0);
         else        enable = ($urandom_range(0, 7) == 0);
         wait_cycles = WW'($urandom_range(0, 5));
         if ($urandom_range(0, 5) == 0) prod_ptr = rnd_ptr();
         if ($urandom_range(0, 5) == 0) cons_ptr = rnd_ptr();
         if ($urandom_range(0, 199) == 0) prod_addr = {$urandom, $urandom};
         if ($urandom_range(0, 199) == 0) cons_addr = {$urandom, $urandom};
      end
      wr_bus.wr_ready_i = rdy;
      wr_bus.wr_ack_i   = ack;

      if (real_ack) begin
         if (m_sel_cons) m_cons_sh = m_data;
         else            m_prod_sh = m_data;
         m_last_cons = m_sel_cons;
         m_pending   = 1'b0;
         m_hsdone    = 1'b0;
         ack_at      = -1;
         free_at     = k + 1 + longint'(wait_cycles);
      end
      if (hs) begin
         m_vld    = 1'b0;
         m_hsdone = 1'b1;
         ack_at   = k + longint'($urandom_range(1, 3));
      end
      dp = (prod_ptr != m_prod_sh);
      dc = (cons_ptr != m_cons_sh);
      if (!m_pending && k >= free_at && enable && (dp || dc)) begin
         m_sel_cons = dp ? (dc ? !m_last_cons : 1'b0) : 1'b1;
         m_data     = m_sel_cons ? cons_ptr : prod_ptr;
         exp_q.push_back({(m_sel_cons ? cons_addr : prod_addr), m_data});
         m_pending  = 1'b1;
         m_vld      = 1'b1;
      end
      m_busy = m_pending || (k + 1 < free_at);
      k++;
   endtask

   // Asynchronous reset in the middle of a cycle; outputs must clear before any clock edge.
   task automatic mid_reset();
      @(negedge clk);
      wr_bus.wr_ack_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(wr_bus.wr_valid_o), 64'd0);
      chk("rst_prod_written", prod_wr, 64'd0);
      chk("rst_cons_written", cons_wr, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      model_reset();
      k++;
      n_rst++;
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Monitor: compares DUT outputs with the model and pops a request on each rising valid.
   bit   prev_v = 1'b0;
   req_t cur;
   always @(posedge clk) begin
      #1;
      if (mon_on) begin
         chk("valid", 64'(wr_bus.wr_valid_o), 64'(m_vld));
         chk("busy", 64'(busy), 64'(m_busy));
         chk("prod_written", prod_wr, m_prod_sh);
         chk("cons_written", cons_wr, m_cons_sh);
         if (wr_bus.wr_valid_o && !prev_v) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_req", 64'(wr_bus.wr_valid_o), 64'd0);
            end else begin
               cur = exp_q.pop_front();
               chk("req_addr", wr_bus.wr_addr_o, cur.addr);
               chk("req_data", wr_bus.wr_data_o, cur.data);
            end
         end else if (wr_bus.wr_valid_o && prev_v) begin
            chk("hold_addr", wr_bus.wr_addr_o, cur.addr);
            chk("hold_data", wr_bus.wr_data_o, cur.data);
         end
         prev_v = wr_bus.wr_valid_o;
      end
   end

   initial begin
      enable            = 1'b1;
      wait_cycles       = '0;
      prod_addr         = 64'h1000;
      cons_addr         = 64'h2000;
      prod_ptr          = 64'h4;
      cons_ptr          = 64'h8;
      wr_bus.wr_ready_i = 1'b0;
      wr_bus.wr_ack_i   = 1'b0;
      k                 = 0;
      model_reset();
      mon_on            = 1'b1;

      repeat (3) @(negedge clk);
      chk("init_valid", 64'(wr_bus.wr_valid_o), 64'd0);
      chk("init_addr", wr_bus.wr_addr_o, 64'd0);
      chk("init_data", wr_bus.wr_data_o, 64'd0);
      chk("init_busy", 64'(busy), 64'd0);
      chk("init_prod_written", prod_wr, 64'd0);
      chk("init_cons_written", cons_wr, 64'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      for (int i = 0; i < 4000; i++) begin
         if (i > 1000 && n_rst == 0 && m_vld) begin
            mid_reset();
         end else if (i > 2000 && n_rst == 1 && m_hsdone) begin
            mid_reset();
         end else begin
            step(1'b1);
         end
      end

      enable = 1'b1;
      repeat (40) step(1'b0);
      chk("drain_prod", prod_wr, prod_ptr);
      chk("drain_cons", cons_wr, cons_ptr);
      chk("drain_queue", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
